dvp_frame_gen: RTL and testbench

Generates a DVP-style camera stream on the pixel clock: data_vsync, data_href and 8-bit source_data, all registered and mutually aligned. It drives the same interface the capture path consumes, and serves as a loopback/test source for the Ethernet subsystem. Pixel bytes come either from an external pull source (ext_req/ext_data, 1-cycle read latency) or from built-in test patterns.

---
 rtl/dvp_frame_gen.sv | 182 ++++++++++++++++++
 tb/tb_dvp_frame_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_frame_gen.sv
// DVP-style test/loopback frame source: data_vsync, data_href, source_data.
// Ports: data_clk, rst, enable, pattern_sel, ext_data/ext_req, frame_done.
module dvp_frame_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic       data_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    input  logic [7:0] ext_data,
    output logic       ext_req,
    output logic       data_href,
    output logic       data_vsync,
    output logic [7:0] source_data,
    output logic       frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int VM1 = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int VM2 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int VMAX = (VM1 > VM2) ? VM1 : VM2;
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int LW = (VMAX > 1) ? $clog2(VMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [LW-1:0] line_q, line_d;
    logic [1:0]    pat_q, pat_d;

    logic          h_last, l_last;
    logic [LW-1:0] len_m1;
    logic          act0, vs0, done0;
    logic [7:0]    h8, l8;

    // Stage 1: counter-derived controls and pixel coordinates.
    logic          act1_q, vs1_q, done1_q;
    logic [7:0]    h1_q, l1_q;
    // Stage 2: pin registers.
    logic          href_q, vsync_q, done_q;
    logic [7:0]    data_q;
    logic [7:0]    pix;

    // Only the low byte of each counter feeds the patterns.
    if (HW >= 8) begin : g_h8w
        assign h8 = h_cnt_q[7:0];
    end else begin : g_h8n
        assign h8 = {{(8-HW){1'b0}}, h_cnt_q};
    end

    if (LW >= 8) begin : g_l8w
        assign l8 = line_q[7:0];
    end else begin : g_l8n
        assign l8 = {{(8-LW){1'b0}}, line_q};
    end

    always_comb begin
        len_m1 = '0;
        case (state_q)
            S_VSYNC:  len_m1 = LW'(V_SYNC - 1);
            S_VBACK:  len_m1 = LW'(V_BACK - 1);
            S_ACTIVE: len_m1 = LW'(V_ACTIVE - 1);
            S_VFRONT: len_m1 = LW'(V_FRONT - 1);
            default:  len_m1 = '0;
        endcase
    end

    assign h_last = (h_cnt_q == HW'(H_TOTAL - 1));
    assign l_last = (line_q == len_m1);

    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        line_d  = line_q;
        pat_d   = pat_q;
        if (state_q == S_IDLE) begin
            if (enable) begin
                state_d = S_VSYNC;
                pat_d   = pattern_sel;
                h_cnt_d = '0;
                line_d  = '0;
            end
        end else begin
            h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
            if (h_last) begin
                if (l_last) begin
                    line_d = '0;
                    case (state_q)
                        S_VSYNC:  state_d = S_VBACK;
                        S_VBACK:  state_d = S_ACTIVE;
                        S_ACTIVE: state_d = S_VFRONT;
                        S_VFRONT: begin
                            // enable only matters at the frame boundary
                            if (enable) begin
                                state_d = S_VSYNC;
                                pat_d   = pattern_sel;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                        default:  state_d = S_IDLE;
                    endcase
                end else begin
                    line_d = line_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge data_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            h_cnt_q <= '0;
            line_q  <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            line_q  <= line_d;
            pat_q   <= pat_d;
        end
    end

    assign act0  = (state_q == S_ACTIVE) && (h_cnt_q < HW'(H_ACTIVE));
    assign vs0   = (state_q == S_VSYNC);
    assign done0 = (state_q == S_VFRONT) && l_last && h_last;

    // Request goes out at stage 0 so the byte lands at stage 1.
    assign ext_req = act0 && (pat_q == 2'd0);

    always_comb begin
        pix = 8'h00;
        case (pat_q)
            2'd0:    pix = ext_data;
            2'd1:    pix = h1_q;
            2'd2:    pix = l1_q;
            default: pix = {8{h1_q[3] ^ l1_q[3]}};
        endcase
    end

    always_ff @(posedge data_clk) begin
        if (rst) begin
            act1_q  <= 1'b0;
            vs1_q   <= 1'b0;
            done1_q <= 1'b0;
            h1_q    <= '0;
            l1_q    <= '0;
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            act1_q  <= act0;
            vs1_q   <= vs0;
            done1_q <= done0;
            h1_q    <= h8;
            l1_q    <= l8;
            href_q  <= act1_q;
            vsync_q <= vs1_q;
            done_q  <= done1_q;
            data_q  <= act1_q ? pix : 8'h00;
        end
    end

    assign data_href   = href_q;
    assign data_vsync  = vsync_q;
    assign source_data = data_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_dvp_frame_gen.sv
// Bench for dvp_frame_gen: frame-position reference model plus
// literal timing pins, small geometry, random enable/pattern/reset.
module tb_dvp_frame_gen;

    localparam int HA = 8;
    localparam int HB = 4;
    localparam int HT = HA + HB;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VA = 3;
    localparam int VF = 1;
    localparam int FR = (VS + VB + VA + VF) * HT;

    logic       data_clk;
    logic       rst;
    logic       enable;
    logic [1:0] pattern_sel;
    logic [7:0] ext_data;
    logic       ext_req;
    logic       data_href;
    logic       data_vsync;
    logic [7:0] source_data;
    logic       frame_done;

    dvp_frame_gen #(
        .H_ACTIVE(HA),
        .H_BLANK (HB),
        .V_SYNC  (VS),
        .V_BACK  (VB),
        .V_ACTIVE(VA),
        .V_FRONT (VF)
    ) dut (
        .data_clk   (data_clk),
        .rst        (rst),
        .enable     (enable),
        .pattern_sel(pattern_sel),
        .ext_data   (ext_data),
        .ext_req    (ext_req),
        .data_href  (data_href),
        .data_vsync (data_vsync),
        .source_data(source_data),
        .frame_done (frame_done)
    );

    initial begin
        data_clk = 1'b0;
        forever #5 data_clk = ~data_clk;
    end

    int checks = 0;
    int fails  = 0;
    bit stop   = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         name, act, exp, $time);
        end
    endtask

    // External pull source: one-cycle latency counter.
    int ext_cnt = 0;
    initial begin
        logic r;
        ext_data = 8'h00;
        forever begin
            @(negedge data_clk);
            r = ext_req;
            @(posedge data_clk);
            #1;
            if (r === 1'b1) begin
                ext_data = ext_cnt[7:0];
                ext_cnt++;
            end else begin
                ext_data = 8'($urandom);
            end
        end
    end

    // Reference model: position within the frame, outputs 2 clocks later.
    typedef struct packed {
        logic       href;
        logic       vs;
        logic       done;
        logic [7:0] data;
    } exp_t;

    bit   m_run = 0;
    int   m_pos = 0;
    int   m_pat = 0;
    int   m_ext = 0;
    exp_t s1 = '0;
    exp_t s2 = '0;

    function automatic bit m_act(bit run, int pos);
        int ln, col;
        ln  = pos / HT;
        col = pos % HT;
        return run && ln >= VS + VB && ln < VS + VB + VA && col < HA;
    endfunction

    task automatic model_step();
        exp_t cur;
        int ln, col, al, v;
        ln  = m_pos / HT;
        col = m_pos % HT;
        al  = ln - (VS + VB);
        cur = '0;
        cur.vs   = m_run && ln < VS;
        cur.href = m_act(m_run, m_pos);
        cur.done = m_run && m_pos == FR - 1;
        if (cur.href) begin
            case (m_pat)
                0: begin
                    cur.data = m_ext[7:0];
                    m_ext++;
                end
                1: cur.data = col[7:0];
                2: cur.data = al[7:0];
                default: begin
                    v = ((col >> 3) ^ (al >> 3)) & 1;
                    cur.data = (v != 0) ? 8'hFF : 8'h00;
                end
            endcase
        end
        if (rst) begin
            s1 = '0;
            s2 = '0;
            m_run = 0;
            m_pos = 0;
        end else begin
            s2 = s1;
            s1 = cur;
            if (!m_run) begin
                if (enable) begin
                    m_run = 1;
                    m_pos = 0;
                    m_pat = int'(pattern_sel);
                end
            end else begin
                m_pos++;
                if (m_pos == FR) begin
                    m_pos = 0;
                    if (enable) m_pat = int'(pattern_sel);
                    else m_run = 0;
                end
            end
        end
    endtask

    initial begin
        while (!stop) begin
            @(posedge data_clk);
            model_step();
            @(negedge data_clk);
            check("href", data_href, s2.href);
            check("vsync", data_vsync, s2.vs);
            check("data", source_data, s2.data);
            check("done", frame_done, s2.done);
            check("ext_req", ext_req,
                  m_act(m_run, m_pos) && m_pat == 0);
            if (data_href && data_vsync) check("hv_excl", 1, 0);
        end
    end

    logic       href_at[0:400];
    logic       vs_at[0:400];
    logic       done_at[0:400];
    logic [7:0] data_at[0:400];
    logic       req_at[0:400];

    task automatic rec(input int k);
        href_at[k] = data_href;
        vs_at[k]   = data_vsync;
        done_at[k] = frame_done;
        data_at[k] = source_data;
        req_at[k]  = ext_req;
    endtask

    initial begin
        int nreq;
        bit any;
        int r;
        rst = 1'b1;
        enable = 1'b0;
        pattern_sel = 2'd0;
        repeat (3) @(negedge data_clk);
        check("rst_href", data_href, 0);
        check("rst_vsync", data_vsync, 0);
        check("rst_data", source_data, 0);
        check("rst_req", ext_req, 0);
        rst = 1'b0;
        @(negedge data_clk);
        pattern_sel = 2'd1;
        enable = 1'b1;
        for (int k = 1; k <= 320; k++) begin
            @(negedge data_clk);
            rec(k);
            if (k == 40)  pattern_sel = 2'd2;
            if (k == 100) pattern_sel = 2'd0;
            if (k == 172) pattern_sel = 2'd3;
            if (k == 250) enable = 1'b0;
        end
        check("vs_c2", vs_at[2], 0);
        check("vs_c3", vs_at[3], 1);
        check("vs_c14", vs_at[14], 1);
        check("vs_c15", vs_at[15], 0);
        check("href_c26", href_at[26], 0);
        check("href_c27", href_at[27], 1);
        for (int i = 0; i < 8; i++)
            check("ramp_l0", data_at[27 + i], i);
        check("href_c35", href_at[35], 0);
        check("href_c39", href_at[39], 1);
        check("href_c51", href_at[51], 1);
        check("ramp_l2", data_at[55], 4);
        check("href_c63", href_at[63], 0);
        check("done_c73", done_at[73], 0);
        check("done_c74", done_at[74], 1);
        check("vs_c75", vs_at[75], 1);
        check("vramp_l0", data_at[99], 0);
        check("vramp_l0b", data_at[104], 0);
        check("vramp_l1", data_at[111], 1);
        check("vramp_l1b", data_at[116], 1);
        check("vramp_l2", data_at[123], 2);
        nreq = 0;
        for (int k = 145; k <= 216; k++) nreq += int'(req_at[k]);
        check("ext_req_cnt", nreq, 24);
        check("done_c290", done_at[290], 1);
        any = 0;
        for (int k = 291; k <= 320; k++)
            any |= href_at[k] | vs_at[k] | done_at[k] | (|data_at[k]);
        check("idle_quiet", any, 0);

        pattern_sel = 2'd1;
        enable = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge data_clk);
            rec(k);
        end
        check("reen_vs3", vs_at[3], 1);
        check("reen_href30", href_at[30], 1);
        check("reen_data30", data_at[30], 3);
        rst = 1'b1;
        @(negedge data_clk);
        check("midrst_href", data_href, 0);
        check("midrst_data", source_data, 0);
        check("midrst_req", ext_req, 0);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge data_clk);
            rec(k);
        end
        check("post_rst_vs2", vs_at[2], 0);
        check("post_rst_vs3", vs_at[3], 1);

        for (int k = 0; k < 3000; k++) begin
            @(negedge data_clk);
            r = $urandom_range(0, 999);
            rst = (r < 3);
            if (r >= 3 && r < 8) enable = ~enable;
            if (r >= 8 && r < 30) pattern_sel = 2'($urandom);
        end
        stop = 1;
        repeat (2) @(negedge data_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
